// File: rtl/reduce_arbiter.sv
// -----------------------------------------------------------------------------
// reduce_arbiter
//   Shares one unary/reduction unit (NOT, AND-, OR-, XOR-reduce) between
//   N_REQ requesters. A round-robin arbiter grants one request at a time. The
//   winner's opcode and operand are captured in IDLE. The result is broadcast
//   for one cycle from EXEC, tagged with the requester id.
//
// Ports:
//   clk          system clock, all state changes on posedge
//   rst_n        asynchronous active-low reset
//   i_req        per-requester request, held until its ack is seen
//   i_op         per-requester opcode, requester i at [2i+1:2i]
//                (00 NOT, 01 AND, 10 OR, 11 XOR)
//   i_a          per-requester operand, requester i at [WIDTH*i +: WIDTH]
//   o_ack        one-hot one-cycle pulse: operand of that requester captured
//   o_busy       high while a transaction is in flight (EXEC)
//   o_res_valid  one-cycle pulse: result outputs valid
//   o_res_id     requester whose result is presented
//   o_res_vec    ~a for NOT, 0 for reductions
//   o_res_bit    &a / |a / ^a for reductions, 0 for NOT
//   o_done_cnt   completed transaction count, wraps at 16 bits
// -----------------------------------------------------------------------------
module reduce_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [2*N_REQ-1:0]     i_op,
  input  logic [WIDTH*N_REQ-1:0] i_a,
  output logic [N_REQ-1:0]       o_ack,
  output logic                   o_busy,
  output logic                   o_res_valid,
  output logic [ID_W-1:0]        o_res_id,
  output logic [WIDTH-1:0]       o_res_vec,
  output logic                   o_res_bit,
  output logic [15:0]            o_done_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // One extra bit so pointer + offset can be formed before wrapping.
  localparam int SUM_W = ID_W + 1;

  // Registered state
  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_id;
  logic [1:0]        r_op;
  logic [WIDTH-1:0]  r_a;
  logic [N_REQ-1:0]  r_ack;
  logic              r_busy;
  logic              r_res_valid;
  logic [ID_W-1:0]   r_res_id;
  logic [WIDTH-1:0]  r_res_vec;
  logic              r_res_bit;
  logic [15:0]       r_done_cnt;

  // Next-state values
  state_t            w_state_next;
  logic [ID_W-1:0]   w_ptr_next;
  logic [ID_W-1:0]   w_id_next;
  logic [1:0]        w_op_next;
  logic [WIDTH-1:0]  w_a_next;
  logic [N_REQ-1:0]  w_ack_next;
  logic              w_busy_next;
  logic              w_res_valid_next;
  logic [ID_W-1:0]   w_res_id_next;
  logic [WIDTH-1:0]  w_res_vec_next;
  logic              w_res_bit_next;
  logic [15:0]       w_done_cnt_next;

  // Per-requester views of the packed opcode/operand buses
  logic [1:0]        w_op [N_REQ];
  logic [WIDTH-1:0]  w_a  [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_op[gi] = i_op[2*gi +: 2];
      assign w_a[gi]  = i_a[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // Round-robin winner search. Offsets are scanned from the farthest to the
  // nearest so that the nearest requester at or above the pointer overwrites
  // the others and wins.
  logic              w_found;
  logic [ID_W-1:0]   w_win;

  always_comb begin
    logic [SUM_W-1:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_idx = SUM_W'(r_ptr) + SUM_W'(k);
      if (v_idx >= SUM_W'(N_REQ)) begin
        v_idx = v_idx - SUM_W'(N_REQ);
      end
      if (i_req[ID_W'(v_idx)]) begin
        w_found = 1'b1;
        w_win   = ID_W'(v_idx);
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_next     = r_state;
    w_ptr_next       = r_ptr;
    w_id_next        = r_id;
    w_op_next        = r_op;
    w_a_next         = r_a;
    w_ack_next       = '0;
    w_busy_next      = 1'b0;
    w_res_valid_next = 1'b0;
    w_res_id_next    = r_res_id;
    w_res_vec_next   = r_res_vec;
    w_res_bit_next   = r_res_bit;
    w_done_cnt_next  = r_done_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_id_next    = w_win;
          w_op_next    = w_op[w_win];
          w_a_next     = w_a[w_win];
          w_ack_next   = N_REQ'(1) << w_win;
          w_ptr_next   = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + ID_W'(1);
          w_busy_next  = 1'b1;
          w_state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // Only the captured copies are used; live inputs may already carry
        // the requester's next transaction.
        w_res_valid_next = 1'b1;
        w_res_id_next    = r_id;
        w_res_vec_next   = '0;
        w_res_bit_next   = 1'b0;
        case (r_op)
          OP_NOT:  w_res_vec_next = ~r_a;
          OP_AND:  w_res_bit_next = &r_a;
          OP_OR:   w_res_bit_next = |r_a;
          OP_XOR:  w_res_bit_next = ^r_a;
          default: w_res_bit_next = 1'b0;
        endcase
        w_done_cnt_next = r_done_cnt + 16'd1;
        w_state_next    = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_ack       <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_vec   <= '0;
      r_res_bit   <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_id        <= w_id_next;
      r_op        <= w_op_next;
      r_a         <= w_a_next;
      r_ack       <= w_ack_next;
      r_busy      <= w_busy_next;
      r_res_valid <= w_res_valid_next;
      r_res_id    <= w_res_id_next;
      r_res_vec   <= w_res_vec_next;
      r_res_bit   <= w_res_bit_next;
      r_done_cnt  <= w_done_cnt_next;
    end
  end

  assign o_ack       = r_ack;
  assign o_busy      = r_busy;
  assign o_res_valid = r_res_valid;
  assign o_res_id    = r_res_id;
  assign o_res_vec   = r_res_vec;
  assign o_res_bit   = r_res_bit;
  assign o_done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_reduce_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reduce_arbiter
//   Checks the arbitrated reduction unit. A transaction-level reference model
//   decides grants and results from the sampled requests. Expected results go
//   into a scoreboard queue. A monitor on the falling edge compares them
//   against what the design presents.
// -----------------------------------------------------------------------------
module tb_reduce_arbiter;
  localparam int N_REQ       = 4;
  localparam int WIDTH       = 8;
  localparam int ID_W        = 2;
  localparam int RAND_CYCLES = 600;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] a;
  logic [N_REQ-1:0]       ack;
  logic                   busy;
  logic                   res_valid;
  logic [ID_W-1:0]        res_id;
  logic [WIDTH-1:0]       res_vec;
  logic                   res_bit;
  logic [15:0]            done_cnt;

  reduce_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (req),
    .i_op       (op),
    .i_a        (a),
    .o_ack      (ack),
    .o_busy     (busy),
    .o_res_valid(res_valid),
    .o_res_id   (res_id),
    .o_res_vec  (res_vec),
    .o_res_bit  (res_bit),
    .o_done_cnt (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] vec;
    logic             rbit;
    logic [15:0]      cnt;
  } res_t;

  res_t res_q[$];

  // Result rules expressed arithmetically on the operand value
  function automatic res_t ref_result(int id, logic [1:0] opc, logic [WIDTH-1:0] val,
                                      logic [15:0] cnt);
    res_t r;
    r.id   = ID_W'(id);
    r.cnt  = cnt;
    r.vec  = '0;
    r.rbit = 1'b0;
    case (opc)
      2'd0:    r.vec  = WIDTH'((1 << WIDTH) - 1 - int'(val));
      2'd1:    r.rbit = (int'(val) == (1 << WIDTH) - 1);
      2'd2:    r.rbit = (int'(val) != 0);
      default: r.rbit = (($countones(val) % 2) == 1);
    endcase
    return r;
  endfunction

  // ---------------- reference model ----------------
  int               m_ptr  = 0;
  bit               m_busy = 1'b0;
  logic [15:0]      m_cnt  = '0;
  logic [N_REQ-1:0] m_ack  = '0;

  always @(posedge clk or negedge rst_n) begin
    int w;
    bit got;
    if (!rst_n) begin
      m_ptr  = 0;
      m_busy = 1'b0;
      m_cnt  = '0;
      m_ack  = '0;
      res_q.delete();
    end else if (m_busy) begin
      m_busy = 1'b0;
      m_ack  = '0;
      m_cnt  = m_cnt + 16'd1;
    end else begin
      m_ack = '0;
      got   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
        w = (m_ptr + k) % N_REQ;
        if (!got && req[w]) begin
          got      = 1'b1;
          m_ack[w] = 1'b1;
          res_q.push_back(ref_result(w, op[2*w +: 2], a[WIDTH*w +: WIDTH], m_cnt + 16'd1));
          m_ptr  = (w + 1) % N_REQ;
          m_busy = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  res_t last_res = '0;
  int   cyc      = 0;
  int   grant_log[$];
  int   grant_cyc[$];

  always @(negedge clk) begin
    res_t got;
    res_t exp;
    cyc++;
    if (!rst_n) last_res = '0;

    vectors++;
    if (ack !== m_ack) begin
      miscompares++;
      $display("FAIL ack: got %b want %b (cycle %0d)", ack, m_ack, cyc);
    end
    vectors++;
    if (busy !== m_busy) begin
      miscompares++;
      $display("FAIL busy: got %b want %b (cycle %0d)", busy, m_busy, cyc);
    end
    vectors++;
    if (done_cnt !== m_cnt) begin
      miscompares++;
      $display("FAIL done_cnt: got %0d want %0d (cycle %0d)", done_cnt, m_cnt, cyc);
    end

    got = {res_id, res_vec, res_bit, done_cnt};
    if (res_valid === 1'b1) begin
      vectors++;
      if (res_q.size() == 0) begin
        miscompares++;
        $display("FAIL res_unexpected: got id=%0d vec=%h bit=%b want no result (cycle %0d)",
                 res_id, res_vec, res_bit, cyc);
        last_res = got;
      end else begin
        exp = res_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL result: got id=%0d vec=%h bit=%b cnt=%0d want id=%0d vec=%h bit=%b cnt=%0d (cycle %0d)",
                   got.id, got.vec, got.rbit, got.cnt, exp.id, exp.vec, exp.rbit, exp.cnt, cyc);
        end else begin
          $display("result id=%0d vec=%h bit=%b cnt=%0d ok", got.id, got.vec, got.rbit, got.cnt);
        end
        last_res = exp;
      end
    end else begin
      vectors++;
      if (res_valid !== 1'b0 || {res_id, res_vec, res_bit} !== {last_res.id, last_res.vec, last_res.rbit}) begin
        miscompares++;
        $display("FAIL res_hold: got v=%b id=%0d vec=%h bit=%b want v=0 id=%0d vec=%h bit=%b (cycle %0d)",
                 res_valid, res_id, res_vec, res_bit, last_res.id, last_res.vec, last_res.rbit, cyc);
      end
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (ack[i] === 1'b1) begin
        grant_log.push_back(i);
        grant_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dcheck(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_a();
    logic [WIDTH-1:0] v;
    case ($urandom_range(4))
      0:       v = '0;
      1:       v = '1;
      2:       v = WIDTH'(1);
      default: v = WIDTH'($urandom);
    endcase
    return v;
  endfunction

  task automatic set_data(int id, logic [1:0] opc, logic [WIDTH-1:0] val);
    op[2*id +: 2]     = opc;
    a[WIDTH*id +: WIDTH] = val;
  endtask

  // Single requester transaction with directed expectations
  task automatic txn(int id, logic [1:0] opc, logic [WIDTH-1:0] val,
                     logic [WIDTH-1:0] exp_vec, logic exp_bit);
    bit seen;
    seen = 1'b0;
    set_data(id, opc, val);
    req[id] = 1'b1;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      if (ack[id] === 1'b1) begin
        seen = 1'b1;
        dcheck("txn_ack", 32'(ack), 32'(1 << id));
      end
    end
    req[id] = 1'b0;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL txn_timeout: got no ack want ack for requester %0d", id);
    end
    tick();
    dcheck("txn_result", 32'({res_valid, res_id, res_vec, res_bit}),
           32'({1'b1, ID_W'(id), exp_vec, exp_bit}));
  endtask

  // Drive a set of simultaneous requests; each drops on its ack
  task automatic serve_mask(logic [N_REQ-1:0] mask);
    for (int i = 0; i < N_REQ; i++) if (mask[i]) set_data(i, 2'($urandom), rand_a());
    req = mask;
    for (int t = 0; t < 40 && req != '0; t++) begin
      tick();
      for (int i = 0; i < N_REQ; i++) if (ack[i] === 1'b1) req[i] = 1'b0;
    end
    if (req != '0) begin
      vectors++;
      miscompares++;
      $display("FAIL serve_timeout: got req left %b want 0", req);
    end
    req = '0;
    tick();
  endtask

  initial begin
    int base;
    logic [N_REQ-1:0] rearm;
    rst_n = 1'b0;
    req   = '0;
    op    = '0;
    a     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    repeat (5) tick();
    dcheck("idle_busy", 32'(busy), 0);
    dcheck("idle_ack", 32'(ack), 0);
    dcheck("idle_res_valid", 32'(res_valid), 0);
    dcheck("idle_done_cnt", 32'(done_cnt), 0);

    // First transaction: NOT of A5 from requester 1
    txn(1, 2'b00, 8'hA5, 8'h5A, 1'b0);
    dcheck("first_done_cnt", 32'(done_cnt), 1);

    // Serve requester 3 so the pointer wraps to 0
    txn(3, 2'b11, 8'h07, 8'h00, 1'b1);

    // All four requesting, each re-raising after its ack
    base = grant_log.size();
    for (int i = 0; i < N_REQ; i++) set_data(i, 2'($urandom), rand_a());
    req   = '1;
    rearm = '0;
    for (int t = 0; t < 60 && grant_log.size() < base + 5; t++) begin
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (rearm[i]) begin
          set_data(i, 2'($urandom), rand_a());
          req[i]   = 1'b1;
          rearm[i] = 1'b0;
        end else if (ack[i] === 1'b1) begin
          req[i]   = 1'b0;
          rearm[i] = 1'b1;
        end
      end
    end
    req = '0;
    if (grant_log.size() < base + 5) begin
      vectors++;
      miscompares++;
      $display("FAIL rr_timeout: got %0d grants want 5", grant_log.size() - base);
    end else begin
      for (int g = 0; g < 5; g++) begin
        dcheck($sformatf("rr_order[%0d]", g), 32'(grant_log[base + g]), 32'(g % N_REQ));
        if (g > 0) dcheck($sformatf("rr_spacing[%0d]", g),
                          32'(grant_cyc[base + g] - grant_cyc[base + g - 1]), 2);
      end
    end
    repeat (3) tick();

    // Opcode sweep on requester 0
    txn(0, 2'b01, 8'hFF, 8'h00, 1'b1);
    txn(0, 2'b10, 8'hFF, 8'h00, 1'b1);
    txn(0, 2'b11, 8'hFF, 8'h00, 1'b0);
    txn(0, 2'b01, 8'h00, 8'h00, 1'b0);
    txn(0, 2'b10, 8'h00, 8'h00, 1'b0);
    txn(0, 2'b11, 8'h00, 8'h00, 1'b0);
    txn(0, 2'b11, 8'h01, 8'h00, 1'b1);
    txn(0, 2'b00, 8'h00, 8'hFF, 1'b0);

    // Pointer fairness: after requester 2, the pointer sits at 3 and wraps
    txn(2, 2'b10, 8'h10, 8'h00, 1'b1);
    base = grant_log.size();
    serve_mask(4'b0101);
    dcheck("fair_first", 32'(grant_log.size() > base ? grant_log[base] : -1), 0);
    dcheck("fair_second", 32'(grant_log.size() > base + 1 ? grant_log[base + 1] : -1), 2);

    // Randomized traffic including withdrawn requests
    for (int t = 0; t < RAND_CYCLES; t++) begin
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i] && ack[i] === 1'b1) begin
          if ($urandom_range(1) == 1) set_data(i, 2'($urandom), rand_a());
          else req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            set_data(i, 2'($urandom), rand_a());
            req[i] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    repeat (4) tick();

    // Reset in the middle of EXEC discards the transaction
    set_data(2, 2'b00, 8'h3C);
    req[2] = 1'b1;
    base = 0;
    for (int t = 0; t < 20 && base == 0; t++) begin
      tick();
      if (ack[2] === 1'b1) base = 1;
    end
    req[2] = 1'b0;
    dcheck("rst_pre_busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    dcheck("rst_ack", 32'(ack), 0);
    dcheck("rst_busy", 32'(busy), 0);
    dcheck("rst_res_valid", 32'(res_valid), 0);
    dcheck("rst_done_cnt", 32'(done_cnt), 0);
    dcheck("rst_res_data", 32'({res_id, res_vec, res_bit}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    dcheck("rst_no_result", 32'(res_valid), 0);
    base = grant_log.size();
    serve_mask(4'b1001);
    dcheck("post_rst_first", 32'(grant_log.size() > base ? grant_log[base] : -1), 0);
    dcheck("post_rst_second", 32'(grant_log.size() > base + 1 ? grant_log[base + 1] : -1), 3);

    repeat (4) tick();
    dcheck("scoreboard_drained", 32'(res_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reduce_arbiter.md
Name: reduce_arbiter

Overview:
- Shares one 8-bit unary/reduction unit (NOT, AND-reduce, OR-reduce, XOR-reduce) between N_REQ requesters.
- Round-robin arbitration, registered operand capture, one-cycle result broadcast tagged with the requester id.
- Sits between the operand-producing blocks and the single shared reduction datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits.
- ID_W, 2, width of requester id; must equal clog2(N_REQ).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  request per requester; held high until its ack is seen.
- op  in  2*N_REQ  per-requester opcode, requester i at bits [2i+1:2i]: 00 NOT, 01 AND, 10 OR, 11 XOR.
- a  in  WIDTH*N_REQ  per-requester operand, requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
- ack  out  N_REQ  one-hot, one-cycle pulse: operand of that requester captured.
- busy  out  1  high while a transaction is in flight (FSM not IDLE).
- res_valid  out  1  one-cycle pulse: result outputs valid.
- res_id  out  ID_W  requester whose result is presented.
- res_vec  out  WIDTH  ~a for op NOT; 0 for reductions.
- res_bit  out  1  &a, |a or ^a for reductions; 0 for NOT.
- done_cnt  out  16  count of completed transactions; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (rst_n low, async): FSM=IDLE, ack=0, busy=0, res_valid=0, res_id=0, res_vec=0, res_bit=0, done_cnt=0, round-robin pointer=0, captured op/operand=0. Applies at any time.
- FSM states: IDLE, EXEC.
- IDLE:
  - If no req bit is set, remain in IDLE.
  - Otherwise pick the winner: first set req bit searching upward from the pointer, wrapping at N_REQ-1 -> 0.
  - On that edge: register the winner's id, op and operand; set ack[winner]=1; set pointer=(winner+1) mod N_REQ; go to EXEC.
- EXEC:
  - Compute from the captured values only; live inputs are ignored.
  - On the edge: ack=0; res_valid=1 with res_id/res_vec/res_bit; done_cnt+1; go to IDLE.
- Default: res_valid and ack are 0 in every cycle not described above. Result data outputs hold their last value after res_valid drops.
- busy: high in EXEC, low in IDLE (registered along with the state).
- Latency: req sampled at edge k -> ack high in cycle k..k+1 -> res_valid high in cycle k+1..k+2. Peak throughput is one transaction per 2 cycles.
- Requester protocol:
  - Drop req (or present new data) in the cycle ack is high. Because req is ignored during EXEC, a req still high in the next IDLE cycle is a new request.
  - op and a must be stable while req is high and ack has not been seen.
- Simultaneous requests: served strictly round-robin. No requester waits more than N_REQ-1 transactions.
- A req that deasserts before it is granted is dropped silently; no ack is issued.
- Reset mid-EXEC: the in-flight transaction is discarded, no res_valid is issued, and the pointer returns to 0.
- Opcode/result encoding (WIDTH=8):
  - NOT: res_vec=~a, res_bit=0.
  - AND: res_vec=0, res_bit=&a.
  - OR: res_vec=0, res_bit=|a.
  - XOR: res_vec=0, res_bit=^a.

Test Plan:
- Reset release, req=0 for 5 cycles -> busy=0, ack=0, res_valid=0, done_cnt=0.
- req[1]=1, op1=00, a1=8'hA5 -> ack=4'b0010 for 1 cycle, then res_valid=1, res_id=1, res_vec=8'h5A, res_bit=0, done_cnt=1.
- req=4'b1111 held (each requester drops req on its ack and re-raises it) -> grants in order 0,1,2,3,0; a res_valid every second cycle.
- Opcode sweep: a0=8'hFF with AND/OR/XOR -> res_bit 1/1/0. a0=8'h00 with AND/OR/XOR -> 0/0/0. a0=8'h01 with XOR -> 1.
- Pointer fairness: serve requester 2 alone, then req=4'b0101 -> requester 0 is granted first (pointer=3 wraps to 0), then requester 2.
- rst_n pulsed low during EXEC -> outputs clear immediately with no res_valid. After release, req=4'b1000|4'b0001 -> requester 0 is granted first.
